fact_arb: RTL and testbench

FACT_ARB -- requirements
Module: fact_arb

---
 rtl/fact_arb_pkg.sv | 22 ++
 rtl/fact_arb_rr_arb2.sv | 14 +
 rtl/fact_arb.sv | 125 ++++++++++++
 tb/tb_fact_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_arb_pkg.sv
// Shared definitions for the factorial-unit arbiter: FSM encoding,
// fact register addresses and STATUS bit positions.
package fact_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_N,
        S_GO,
        S_POLL,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [1:0] FACT_N   = 2'd0;
    localparam logic [1:0] FACT_GO  = 2'd1;
    localparam logic [1:0] FACT_ST  = 2'd2;
    localparam logic [1:0] FACT_RES = 2'd3;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;

endpackage

// File: rtl/fact_arb_rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to
// the requester that was not served last.
module rr_arb2
    import fact_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/fact_arb.sv
// Shares one factorial register block between two requesters; runs the
// write-N / GO / poll / read-result sequence for each granted job.
module fact_arb
    import fact_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  n0,
    input  logic [3:0]  n1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res,
    output logic        err,
    output logic        busy,
    output logic [1:0]  f_a,
    output logic        f_we,
    output logic [31:0] f_wd,
    input  logic [31:0] f_rd
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          id;
    logic          last;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic [3:0]    n_sel;

    rr_arb2 u_rr (
        .req   ({req1, req0}),
        .last  (last),
        .grant (grant)
    );

    assign n_sel = grant[1] ? n1 : n0;

    // Outputs are registered alongside the state: each transition loads
    // the values the next state presents, so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            id    <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            f_a   <= FACT_ST;
            f_we  <= 1'b0;
            f_wd  <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res   <= '0;
            err   <= 1'b0;
            f_we  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        id    <= grant[1];
                        gnt0  <= grant[0];
                        gnt1  <= grant[1];
                        f_a   <= FACT_N;
                        f_we  <= 1'b1;
                        f_wd  <= {28'b0, n_sel};
                        busy  <= 1'b1;
                        state <= S_LOAD_N;
                    end
                end
                S_LOAD_N: begin
                    f_a   <= FACT_GO;
                    f_we  <= 1'b1;
                    f_wd  <= 32'd1;
                    state <= S_GO;
                end
                S_GO: begin
                    f_a   <= FACT_ST;
                    cnt   <= '0;
                    state <= S_POLL;
                end
                S_POLL: begin
                    cnt <= cnt + 1'b1;
                    // Err beats Done, and Done beats the timeout.
                    if (f_rd[ST_ERR] || (!f_rd[ST_DONE] && cnt == CNT_LAST)) begin
                        err   <= 1'b1;
                        done0 <= ~id;
                        done1 <= id;
                        state <= S_RESP;
                    end else if (f_rd[ST_DONE]) begin
                        f_a   <= FACT_RES;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    res   <= f_rd;
                    done0 <= ~id;
                    done1 <= id;
                    f_a   <= FACT_ST;
                    state <= S_RESP;
                end
                S_RESP: begin
                    last  <= id;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_arb.sv
// Bench for fact_arb: a register-level model of the factorial unit, a
// job-timeline reference checked every cycle, and directed literal cases.
module tb_fact_arb;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  n0 = '0, n1 = '0;
    logic        gnt0, gnt1, done0, done1, err, busy, f_we;
    logic [31:0] res, f_wd, f_rd;
    logic [1:0]  f_a;

    always #5 clk = ~clk;

    fact_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .res(res),
        .err(err), .busy(busy), .f_a(f_a), .f_we(f_we), .f_wd(f_wd), .f_rd(f_rd)
    );

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    bit     chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Done shows up on POLL read number poll_k(n); n > 12 overflows and
    // reports Err on the 2nd read; never_done models a hung unit.
    function automatic int poll_k(input int n);
        return (n + 1) % 4 + 1;
    endfunction

    // ---- factorial register block model ----
    logic [3:0] fn = '0;
    int         pcount = 0;
    bit         never_done = 0;

    always_comb begin
        f_rd = '0;
        case (f_a)
            2'd0: f_rd = {28'b0, fn};
            2'd2: begin
                f_rd[1] = (fn > 4'd12) && (pcount >= 1);
                f_rd[0] = !never_done && (fn <= 4'd12) && (pcount >= poll_k(int'(fn)) - 1);
            end
            2'd3: f_rd = fact(int'(fn));
            default: f_rd = '0;
        endcase
    end

    always @(posedge clk) begin
        if (f_we && f_a == 2'd0) fn <= f_wd[3:0];
        if (f_we && f_a == 2'd1) pcount <= 0;
        else if (f_a == 2'd2 && pcount < 100000) pcount <= pcount + 1;
    end

    // ---- input snapshots at the sampling edge ----
    logic       s_rst = 1'b1, s_req0 = 1'b0, s_req1 = 1'b0;
    logic [3:0] s_n0 = '0, s_n1 = '0;
    always @(posedge clk) begin
        s_rst  <= rst;
        s_req0 <= req0;
        s_req1 <= req1;
        s_n0   <= n0;
        s_n1   <= n1;
    end

    // ---- job-level reference: one job = a timeline of cycle offsets ----
    typedef struct { int id; longint cyc; } gnt_rec_t;
    typedef struct { int id; logic [31:0] res; logic err; longint cyc; int npoll; int wtrace; } done_rec_t;
    gnt_rec_t  gnt_q[$];
    done_rec_t done_q[$];

    bit m_busy = 0, m_ok = 0;
    int m_id = 0, m_n = 0, m_off = 0, m_end = 0, m_last = 1;
    int wtrace = 0, npoll = 0;

    initial begin
        logic [1:0]  e_gnt, e_done;
        logic [31:0] e_res;
        logic        e_err, e_we, chk_fa;
        logic [1:0]  e_fa;
        logic [31:0] e_wd;
        int          p;
        done_rec_t   d;
        forever begin
            @(negedge clk);
            cyc++;
            if (s_rst) begin
                m_busy = 0;
                m_last = 1;
            end else if (m_busy) begin
                if (m_off == m_end) begin
                    m_busy = 0;
                    m_last = m_id;
                end else m_off++;
            end else if (s_req0 || s_req1) begin
                m_id   = (s_req0 && s_req1) ? (m_last == 1 ? 0 : 1) : (s_req0 ? 0 : 1);
                m_n    = m_id ? int'(s_n1) : int'(s_n0);
                m_off  = 1;
                m_busy = 1;
                if (m_n > 12)       begin p = 2;       m_ok = 0; end
                else if (never_done) begin p = TIMEOUT; m_ok = 0; end
                else                begin p = poll_k(m_n); m_ok = 1; end
                m_end = m_ok ? 4 + p : 3 + p;
            end

            e_gnt = '0; e_done = '0; e_res = '0; e_err = 0;
            e_we = 0; e_fa = 2'd2; e_wd = '0; chk_fa = 1;
            if (m_busy) begin
                if (m_off == 1) begin
                    e_gnt[m_id] = 1; e_we = 1; e_fa = 2'd0; e_wd = 32'(m_n);
                end else if (m_off == 2) begin
                    e_we = 1; e_fa = 2'd1; e_wd = 32'd1;
                end else if (m_off == m_end) begin
                    e_done[m_id] = 1; e_res = m_ok ? fact(m_n) : 32'd0; e_err = !m_ok; chk_fa = 0;
                end else if (m_ok && m_off == m_end - 1) begin
                    e_fa = 2'd3;
                end
            end

            if (chk_en) begin
                chk("gnt",  {gnt1, gnt0},   e_gnt);
                chk("done", {done1, done0}, e_done);
                chk("res",  res,  e_res);
                chk("err",  err,  e_err);
                chk("busy", busy, m_busy);
                chk("f_we", f_we, e_we);
                if (chk_fa) chk("f_a", f_a, e_fa);
                if (e_we)   chk("f_wd", f_wd, e_wd);
            end

            // Event log for the directed cases
            if (gnt0 || gnt1) begin
                gnt_q.push_back('{id: gnt1 ? 1 : 0, cyc: cyc});
                wtrace = 0;
                npoll  = 0;
            end
            if (f_we) wtrace = wtrace * 4 + int'(f_a) + 1;
            if (busy && f_a == 2'd2 && !f_we && !done0 && !done1) npoll++;
            if (done0 || done1) begin
                d = '{id: done1 ? 1 : 0, res: res, err: err, cyc: cyc, npoll: npoll, wtrace: wtrace};
                done_q.push_back(d);
                // exactly one write to N then one to GO per job
                if (chk_en) chk("wr_trace", wtrace, 6);
            end
        end
    end

    // ---- stimulus helpers ----
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output gnt_rec_t g, input int budget);
        g = '{id: -1, cyc: 0};
        for (int i = 0; i < budget; i++) begin
            step();
            if (gnt_q.size() > 0) begin
                g = gnt_q.pop_front();
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_gnt: no grant within %0d cycles", budget);
    endtask

    task automatic wait_done(output done_rec_t r, input int budget);
        r = '{id: -1, res: 32'hdead, err: 1'bx, cyc: 0, npoll: -1, wtrace: -1};
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() > 0) begin
                r = done_q.pop_front();
                return;
            end
            step();
        end
        checks++; errors++;
        $display("FAIL wait_done: no completion within %0d cycles", budget);
    endtask

    initial begin
        gnt_rec_t  g;
        done_rec_t r;
        int        ids[4];
        int        rsv[4];
        int        n_done0;

        do_reset();
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_f_a",  f_a, 2);
        chk("rst_f_we", f_we, 0);
        chk("rst_outs", {gnt0, gnt1, done0, done1, err}, 0);
        chk("rst_res",  res, 0);
        #2;

        // n0=5: Done on 3rd POLL read -> 120; request cycle to done
        // cycle inclusive is 5 + 3 = 8 cycles.
        gnt_q.delete(); done_q.delete();
        req0 = 1; n0 = 4'd5;
        wait_gnt(g, 10);
        req0 = 0; n0 = 4'd9;
        wait_done(r, 30);
        chk("j30_gid",  g.id, 0);
        chk("j30_id",   r.id, 0);
        chk("j30_res",  r.res, 120);
        chk("j30_err",  r.err, 0);
        chk("j30_poll", r.npoll, 3);
        chk("j30_lat",  r.cyc - g.cyc + 2, 8);

        // Both held high after reset: 0,1,0,1 alternation
        do_reset();
        gnt_q.delete(); done_q.delete();
        req0 = 1; req1 = 1; n0 = 4'd3; n1 = 4'd4;
        for (int k = 0; k < 4; k++) begin
            wait_done(r, 40);
            ids[k] = r.id;
            rsv[k] = int'(r.res);
        end
        req0 = 0; req1 = 0;
        chk("rr_id0", ids[0], 0); chk("rr_res0", rsv[0], 6);
        chk("rr_id1", ids[1], 1); chk("rr_res1", rsv[1], 24);
        chk("rr_id2", ids[2], 0); chk("rr_res2", rsv[2], 6);
        chk("rr_id3", ids[3], 1); chk("rr_res3", rsv[3], 24);
        step();

        // n1=13 overflows -> Err
        gnt_q.delete(); done_q.delete();
        req1 = 1; n1 = 4'd13;
        wait_gnt(g, 10);
        req1 = 0;
        wait_done(r, 30);
        chk("e32_id",  r.id, 1);
        chk("e32_err", r.err, 1);
        chk("e32_res", r.res, 0);
        repeat (3) step();
        n_done0 = 0;
        foreach (done_q[i]) if (done_q[i].id == 0) n_done0++;
        chk("e32_no0", n_done0 + gnt_q.size(), 0);

        // Unit never finishes -> timeout after TIMEOUT POLL cycles
        gnt_q.delete(); done_q.delete();
        never_done = 1;
        req0 = 1; n0 = 4'd7;
        wait_gnt(g, 10);
        req0 = 0;
        wait_done(r, TIMEOUT + 40);
        chk("t33_id",   r.id, 0);
        chk("t33_err",  r.err, 1);
        chk("t33_res",  r.res, 0);
        chk("t33_poll", r.npoll, TIMEOUT);
        never_done = 0;
        step();

        // Reset mid-POLL aborts silently; req1 alone then served
        gnt_q.delete(); done_q.delete();
        req0 = 1; n0 = 4'd6;
        wait_gnt(g, 10);
        req0 = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("r34_busy", busy, 0);
        chk("r34_we",   f_we, 0);
        #2;
        repeat (4) step();
        chk("r34_nodone", done_q.size(), 0);
        req1 = 1; n1 = 4'd2;
        wait_gnt(g, 10);
        req1 = 0;
        chk("r34_gid", g.id, 1);
        wait_done(r, 30);
        chk("r34_id",  r.id, 1);
        chk("r34_res", r.res, 2);

        // Randomized traffic, n wiggling every cycle, rare resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) req0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) req1 = 1'($urandom_range(0, 1));
            n0  = 4'($urandom_range(0, 15));
            n1  = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; req0 = 0; req1 = 0;
        for (int k = 0; k < 100 && busy; k++) step();
        chk("drain_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
